// File: rtl/acq_search_ctrl.sv
// GPS acquisition search controller: sweeps Doppler bins and code-phase windows,
// scans each dump for a peak-to-mean detection and confirms it before locking.
// Build option ACQ_ABS_EN: absolute-value magnitude (else negatives clamp to 0).
module acq_search_ctrl #(
    parameter int          N_CH        = 128,
    parameter int          ACC_W       = 32,
    parameter int          N_DOPP      = 21,
    parameter logic [31:0] DOPP_CENTER = 32'h0,
    parameter logic [31:0] DOPP_STEP   = 32'd2684,
    parameter int          PHASE_STEP  = 32,
    parameter int          N_WIN       = 32,
    parameter int          THR_SHIFT   = 3,
    parameter int          CONFIRM_N   = 3,
    parameter int          LOSS_N      = 4
) (
    input  logic                             CLK_16M,
    input  logic                             RST,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             dump,
    input  logic [N_CH*ACC_W-1:0]            coef_flat,
    output logic [31:0]                      doppler_tw,
    output logic [9:0]                       phase,
    output logic [$clog2(N_CH)-1:0]          max_ID,
    output logic [ACC_W+$clog2(N_CH)-1:0]    peak_val,
    output logic                             busy,
    output logic                             locked,
    output logic                             acq_fail
);
    localparam int IDX_W  = $clog2(N_CH);
    localparam int SUM_W  = ACC_W + IDX_W;
    localparam int CMP_W  = SUM_W + IDX_W + THR_SHIFT;
    localparam int BIN_W  = $clog2(N_DOPP + 1);
    localparam int WIN_W  = $clog2(N_WIN + 1);
    localparam int CNF_W  = $clog2(CONFIRM_N + 1);
    localparam int MISS_W = $clog2(LOSS_N + 1);
    localparam int HALF   = (N_DOPP - 1) / 2;
    localparam int PSTEP  = PHASE_STEP % 1023;

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COLLECT, S_SCAN, S_EVAL, S_LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [BIN_W-1:0]        bin_q, bin_d;
    logic [WIN_W-1:0]        win_q, win_d;
    logic [9:0]              phase_q, phase_d, ph_out_q, ph_out_d;
    logic [31:0]             tw_q, tw_d;
    logic [N_CH*ACC_W-1:0]   coef_q, coef_d;
    logic [IDX_W-1:0]        ch_q, ch_d, max_idx_q, max_idx_d, max_id_q, max_id_d, cand_q, cand_d;
    logic [SUM_W-1:0]        sum_q, sum_d, peak_q, peak_d;
    logic [ACC_W-1:0]        max_q, max_d, mag;
    logic                    cand_vld_q, cand_vld_d, lock_mode_q, lock_mode_d;
    logic                    locked_q, locked_d, fail_q, fail_d, detect;
    logic [CNF_W-1:0]        conf_q, conf_d;
    logic [MISS_W-1:0]       miss_q, miss_d;
    logic [10:0]             ph_sum;
    logic [9:0]              ph_next;

    function automatic logic [31:0] tw_of(input logic [BIN_W-1:0] b);
        return DOPP_CENTER + 32'(b) * DOPP_STEP - 32'(HALF) * DOPP_STEP;
    endfunction

    function automatic logic [ACC_W-1:0] mag_of(input logic [ACC_W-1:0] w);
`ifdef ACQ_ABS_EN
        if (w == {1'b1, {(ACC_W-1){1'b0}}}) return {1'b0, {(ACC_W-1){1'b1}}};
        else if (w[ACC_W-1])                return -w;
        else                                return w;
`else
        return w[ACC_W-1] ? '0 : w;
`endif
    endfunction

    always_comb begin
        mag     = mag_of(coef_q[ACC_W-1:0]);
        detect  = (CMP_W'(max_q) << IDX_W) > (CMP_W'(sum_q) << THR_SHIFT);
        ph_sum  = {1'b0, phase_q} + 11'(PSTEP);
        ph_next = (ph_sum >= 11'd1023) ? 10'(ph_sum - 11'd1023) : ph_sum[9:0];
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        win_d       = win_q;
        phase_d     = phase_q;
        coef_d      = coef_q;
        ch_d        = ch_q;
        sum_d       = sum_q;
        max_d       = max_q;
        max_idx_d   = max_idx_q;
        max_id_d    = max_id_q;
        peak_d      = peak_q;
        cand_d      = cand_q;
        cand_vld_d  = cand_vld_q;
        conf_d      = conf_q;
        miss_d      = miss_q;
        lock_mode_d = lock_mode_q;
        fail_d      = fail_q;
        tw_d        = tw_of(bin_q);
        ph_out_d    = phase_q;
        locked_d    = lock_mode_q;
        case (state_q)
            S_IDLE: if (start && !abort) begin
                state_d    = S_SETTLE;
                bin_d      = '0;
                win_d      = '0;
                phase_d    = '0;
                fail_d     = 1'b0;
                conf_d     = '0;
                cand_vld_d = 1'b0;
                miss_d     = '0;
                tw_d       = tw_of('0);
                ph_out_d   = '0;
            end
            S_SETTLE: if (dump) state_d = S_COLLECT;
            S_COLLECT, S_LOCKED: if (dump) begin
                state_d   = S_SCAN;
                coef_d    = coef_flat;
                ch_d      = '0;
                sum_d     = '0;
                max_d     = '0;
                max_idx_d = '0;
            end
            S_SCAN: begin
                coef_d = coef_q >> ACC_W;
                sum_d  = sum_q + SUM_W'(mag);
                // strict compare keeps the lowest index on ties
                if (mag > max_q) begin
                    max_d     = mag;
                    max_idx_d = ch_q;
                end
                ch_d = ch_q + IDX_W'(1);
                if (ch_q == IDX_W'(N_CH - 1)) state_d = S_EVAL;
            end
            S_EVAL: begin
                peak_d   = SUM_W'(max_q);
                max_id_d = max_idx_q;
                if (lock_mode_q) begin
                    if (detect) begin
                        miss_d  = '0;
                        state_d = S_LOCKED;
                    end else if (miss_q == MISS_W'(LOSS_N - 1)) begin
                        lock_mode_d = 1'b0;
                        bin_d       = '0;
                        win_d       = '0;
                        phase_d     = '0;
                        conf_d      = '0;
                        cand_vld_d  = 1'b0;
                        miss_d      = '0;
                        fail_d      = 1'b0;
                        state_d     = S_SETTLE;
                    end else begin
                        miss_d  = miss_q + MISS_W'(1);
                        state_d = S_LOCKED;
                    end
                end else if (detect) begin
                    cand_d     = max_idx_q;
                    cand_vld_d = 1'b1;
                    if (!cand_vld_q || max_idx_q == cand_q) begin
                        conf_d = conf_q + CNF_W'(1);
                        if (conf_q == CNF_W'(CONFIRM_N - 1)) begin
                            lock_mode_d = 1'b1;
                            miss_d      = '0;
                            state_d     = S_LOCKED;
                        end else begin
                            state_d = S_COLLECT;
                        end
                    end else begin
                        conf_d  = CNF_W'(1);
                        state_d = S_COLLECT;
                    end
                end else begin
                    conf_d     = '0;
                    cand_vld_d = 1'b0;
                    state_d    = S_SETTLE;
                    if (bin_q == BIN_W'(N_DOPP - 1)) begin
                        bin_d   = '0;
                        win_d   = win_q + WIN_W'(1);
                        phase_d = ph_next;
                        if (win_q == WIN_W'(N_WIN - 1)) begin
                            fail_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        bin_d = bin_q + BIN_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // abort freezes the visible search position and results
        if (abort) begin
            state_d     = S_IDLE;
            lock_mode_d = 1'b0;
            bin_d       = bin_q;
            win_d       = win_q;
            phase_d     = phase_q;
            fail_d      = fail_q;
            peak_d      = peak_q;
            max_id_d    = max_id_q;
        end
    end

    always_ff @(posedge CLK_16M or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            bin_q       <= '0;
            win_q       <= '0;
            phase_q     <= '0;
            coef_q      <= '0;
            ch_q        <= '0;
            sum_q       <= '0;
            max_q       <= '0;
            max_idx_q   <= '0;
            max_id_q    <= '0;
            peak_q      <= '0;
            cand_q      <= '0;
            cand_vld_q  <= 1'b0;
            conf_q      <= '0;
            miss_q      <= '0;
            lock_mode_q <= 1'b0;
            fail_q      <= 1'b0;
            tw_q        <= tw_of('0);
            ph_out_q    <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            win_q       <= win_d;
            phase_q     <= phase_d;
            coef_q      <= coef_d;
            ch_q        <= ch_d;
            sum_q       <= sum_d;
            max_q       <= max_d;
            max_idx_q   <= max_idx_d;
            max_id_q    <= max_id_d;
            peak_q      <= peak_d;
            cand_q      <= cand_d;
            cand_vld_q  <= cand_vld_d;
            conf_q      <= conf_d;
            miss_q      <= miss_d;
            lock_mode_q <= lock_mode_d;
            fail_q      <= fail_d;
            tw_q        <= tw_d;
            ph_out_q    <= ph_out_d;
            locked_q    <= locked_d;
        end
    end

    assign doppler_tw = tw_q;
    assign phase      = ph_out_q;
    assign max_ID     = max_id_q;
    assign peak_val   = peak_q;
    assign busy       = (state_q != S_IDLE);
    assign locked     = locked_q;
    assign acq_fail   = fail_q;
endmodule

// File: tb/tb_acq_search_ctrl.sv
// Directed bench for acq_search_ctrl with a small configuration (8 channels, 3 bins, 2 windows).
module tb_acq_search_ctrl;
    localparam int N_CH  = 8;
    localparam int ACC_W = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0, abort = 1'b0, dump = 1'b0;
    logic [N_CH*ACC_W-1:0] coef = '0;
    logic [31:0]           doppler_tw;
    logic [9:0]            phase;
    logic [2:0]            max_ID;
    logic [34:0]           peak_val;
    logic                  busy, locked, acq_fail;
    int                    total = 0;
    int                    bad = 0;

    acq_search_ctrl #(
        .N_CH(8), .ACC_W(32), .N_DOPP(3), .DOPP_CENTER(32'd1000), .DOPP_STEP(32'd100),
        .PHASE_STEP(32), .N_WIN(2), .THR_SHIFT(1), .CONFIRM_N(2), .LOSS_N(2)
    ) dut (
        .CLK_16M(clk), .RST(rst), .start(start), .abort(abort), .dump(dump),
        .coef_flat(coef), .doppler_tw(doppler_tw), .phase(phase), .max_ID(max_ID),
        .peak_val(peak_val), .busy(busy), .locked(locked), .acq_fail(acq_fail)
    );

    always #5 clk = ~clk;

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < N_CH; i++) coef[i*ACC_W +: ACC_W] = v;
    endtask

    task automatic set_one(input int idx, input logic [31:0] v, input logic [31:0] others);
        for (int i = 0; i < N_CH; i++) coef[i*ACC_W +: ACC_W] = (i == idx) ? v : others;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_dump();
        @(negedge clk) dump = 1'b1;
        @(negedge clk) dump = 1'b0;
    endtask

    task automatic dump_wait();
        pulse_dump();
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (doppler_tw !== 32'd900) begin bad++; $display("FAIL reset_tw got=%0d want=900", doppler_tw); end
        total++; if (phase !== 10'd0) begin bad++; $display("FAIL reset_phase got=%0d want=0", phase); end
        total++; if ({busy, locked, acq_fail} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, locked, acq_fail}); end
        total++; if (max_ID !== 3'd0 || peak_val !== 35'd0) begin bad++; $display("FAIL reset_peak got=%0d/%0d want=0/0", max_ID, peak_val); end
    endtask

    task automatic test_sweep_fail();
        logic [31:0] exp_tw [6];
        exp_tw = '{32'd900, 32'd1000, 32'd1100, 32'd900, 32'd1000, 32'd1100};
        set_all(32'd10);
        pulse_start();
        total++; if (busy !== 1'b1 || doppler_tw !== 32'd900) begin bad++; $display("FAIL start_busy got=%b/%0d want=1/900", busy, doppler_tw); end
        for (int b = 0; b < 6; b++) begin
            total++;
            if (doppler_tw !== exp_tw[b] || phase !== ((b < 3) ? 10'd0 : 10'd32) || acq_fail !== 1'b0) begin
                bad++;
                $display("FAIL sweep_step%0d got tw=%0d ph=%0d fail=%b want tw=%0d ph=%0d fail=0",
                         b, doppler_tw, phase, acq_fail, exp_tw[b], (b < 3) ? 0 : 32);
            end
            dump_wait();
            dump_wait();
        end
        total++; if (acq_fail !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL sweep_end got fail=%b busy=%b want 1/0", acq_fail, busy); end
        total++; if (max_ID !== 3'd0 || peak_val !== 35'd10) begin bad++; $display("FAIL sweep_tie got=%0d/%0d want=0/10", max_ID, peak_val); end
    endtask

    task automatic test_lock();
        set_one(5, 32'd400, 32'd10);
        pulse_start();
        total++; if (acq_fail !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL lock_start got fail=%b busy=%b want 0/1", acq_fail, busy); end
        dump_wait();
        dump_wait();
        total++; if (locked !== 1'b0 || max_ID !== 3'd5 || peak_val !== 35'd400) begin bad++; $display("FAIL lock_first got l=%b id=%0d pk=%0d want 0/5/400", locked, max_ID, peak_val); end
        pulse_dump();
        repeat (9) @(negedge clk);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%b want=0", locked); end
        @(negedge clk);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_edge got=%b want=1", locked); end
        repeat (2) @(negedge clk);
        total++; if (doppler_tw !== 32'd900 || phase !== 10'd0 || max_ID !== 3'd5) begin bad++; $display("FAIL lock_hold got tw=%0d ph=%0d id=%0d want 900/0/5", doppler_tw, phase, max_ID); end
    endtask

    task automatic test_loss();
        set_all(32'd10);
        dump_wait();
        total++; if (locked !== 1'b1 || doppler_tw !== 32'd900) begin bad++; $display("FAIL loss_one got l=%b tw=%0d want 1/900", locked, doppler_tw); end
        dump_wait();
        total++; if (locked !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL loss_two got l=%b busy=%b want 0/1", locked, busy); end
        total++; if (doppler_tw !== 32'd900 || phase !== 10'd0 || peak_val !== 35'd10) begin bad++; $display("FAIL loss_restart got tw=%0d ph=%0d pk=%0d want 900/0/10", doppler_tw, phase, peak_val); end
    endtask

    task automatic test_alternate();
        dump_wait();
        for (int k = 0; k < 4; k++) begin
            set_one((k % 2 == 0) ? 2 : 6, 32'd400, 32'd10);
            dump_wait();
            total++;
            if (locked !== 1'b0 || max_ID !== ((k % 2 == 0) ? 3'd2 : 3'd6)) begin
                bad++;
                $display("FAIL alt_%0d got l=%b id=%0d want 0/%0d", k, locked, max_ID, (k % 2 == 0) ? 2 : 6);
            end
        end
        set_one(6, 32'd400, 32'd10);
        dump_wait();
        total++; if (locked !== 1'b1 || max_ID !== 3'd6 || doppler_tw !== 32'd900) begin bad++; $display("FAIL alt_stable got l=%b id=%0d tw=%0d want 1/6/900", locked, max_ID, doppler_tw); end
    endtask

    task automatic test_abort();
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || locked !== 1'b0 || acq_fail !== 1'b0) begin bad++; $display("FAIL abort_flags got b=%b l=%b f=%b want 000", busy, locked, acq_fail); end
        total++; if (doppler_tw !== 32'd900 || max_ID !== 3'd6 || peak_val !== 35'd400) begin bad++; $display("FAIL abort_hold got tw=%0d id=%0d pk=%0d want 900/6/400", doppler_tw, max_ID, peak_val); end
    endtask

    task automatic test_busy_start();
        set_all(32'd10);
        pulse_start();
        dump_wait();
        dump_wait();
        total++; if (doppler_tw !== 32'd1000) begin bad++; $display("FAIL busy_bin1 got=%0d want=1000", doppler_tw); end
        pulse_start();
        repeat (3) @(negedge clk);
        total++; if (doppler_tw !== 32'd1000 || busy !== 1'b1) begin bad++; $display("FAIL busy_start_ignored got tw=%0d busy=%b want 1000/1", doppler_tw, busy); end
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
    endtask

    task automatic test_abs();
        pulse_start();
        set_one(3, 32'h8000_0000, 32'd0);
        dump_wait();
        dump_wait();
`ifdef ACQ_ABS_EN
        total++; if (max_ID !== 3'd3 || peak_val !== 35'h7FFF_FFFF || doppler_tw !== 32'd900) begin bad++; $display("FAIL abs_sat got id=%0d pk=%0d tw=%0d want 3/2147483647/900", max_ID, peak_val, doppler_tw); end
`else
        total++; if (max_ID !== 3'd0 || peak_val !== 35'd0 || doppler_tw !== 32'd1000) begin bad++; $display("FAIL clamp_neg got id=%0d pk=%0d tw=%0d want 0/0/1000", max_ID, peak_val, doppler_tw); end
`endif
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
    endtask

    task automatic test_rst_mid_scan();
        set_one(5, 32'd400, 32'd10);
        pulse_start();
        dump_wait();
        dump_wait();
        total++; if (max_ID !== 3'd5 || peak_val !== 35'd400) begin bad++; $display("FAIL rst_pre got id=%0d pk=%0d want 5/400", max_ID, peak_val); end
        pulse_dump();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || locked !== 1'b0 || max_ID !== 3'd0 || peak_val !== 35'd0 || doppler_tw !== 32'd900) begin
            bad++; $display("FAIL rst_mid got b=%b l=%b id=%0d pk=%0d tw=%0d want 0/0/0/0/900", busy, locked, max_ID, peak_val, doppler_tw);
        end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        total++; if (busy !== 1'b0 || peak_val !== 35'd0) begin bad++; $display("FAIL rst_after got b=%b pk=%0d want 0/0", busy, peak_val); end
    endtask

    initial begin
        test_reset();
        test_sweep_fail();
        test_lock();
        test_loss();
        test_alternate();
        test_abort();
        test_busy_start();
        test_abs();
        test_rst_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
